// File: rtl/window_3x3_gen.sv
// Sliding 3x3 neighbourhood generator for a raster pixel stream.
// Two line buffers supply the rows above; one window is emitted per interior pixel.
module window_3x3_gen #(
  parameter int IMG_W  = 250,
  parameter int IMG_H  = 114,
  parameter int DATA_W = 8,
  parameter int COL_W  = 8,
  parameter int ROW_W  = 7
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  frame_start,
  input  logic                  pix_valid,
  input  logic [DATA_W-1:0]     pix_data,
  output logic                  win_valid,
  output logic [9*DATA_W-1:0]   win_data,
  output logic [COL_W-1:0]      win_col,
  output logic [ROW_W-1:0]      win_row,
  output logic                  win_eof
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]  in_col, eff_col;
  logic [ROW_W-1:0]  in_row, eff_row;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [DATA_W-1:0] col_in [3];
  logic [DATA_W-1:0] tap_c1 [3];
  logic [DATA_W-1:0] tap_c2 [3];
  logic [9*DATA_W-1:0] next_window;
  logic              win_hit;
  logic              last_pix;

  // frame_start re-aligns the position before this cycle's pixel is placed.
  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    eff_col = in_col;
    eff_row = in_row;
    if (frame_start) begin
      eff_col = '0;
      eff_row = '0;
    end
  end

  assign lb0_rd   = lb0[eff_col];
  assign lb1_rd   = lb1[eff_col];
  assign win_hit  = pix_valid && (eff_row >= ROW_TWO) && (eff_col >= COL_TWO);
  assign last_pix = (eff_row == LAST_ROW) && (eff_col == LAST_COL);

  // Incoming right-hand column, top to bottom.
  always_comb begin
    col_in[0] = lb1_rd;
    col_in[1] = lb0_rd;
    col_in[2] = pix_data;
  end

  // Window after the shift: old c1 becomes c0, old c2 becomes c1, new column is c2.
  always_comb begin
    next_window = '0;
    for (int r = 0; r < 3; r++) begin
      next_window[(3*r + 0)*DATA_W +: DATA_W] = tap_c1[r];
      next_window[(3*r + 1)*DATA_W +: DATA_W] = tap_c2[r];
      next_window[(3*r + 2)*DATA_W +: DATA_W] = col_in[r];
    end
  end

  // NOTE: line buffer RAM has no reset so it maps onto block RAM; stale contents are masked by the row/col gating.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb1[eff_col] <= lb0[eff_col];
      lb0[eff_col] <= pix_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_col <= '0;
      in_row <= '0;
    end else if (pix_valid) begin
      if (eff_col == LAST_COL) begin
        in_col <= '0;
        in_row <= (eff_row == LAST_ROW) ? '0 : eff_row + ROW_ONE;
      end else begin
        in_col <= eff_col + COL_ONE;
        in_row <= eff_row;
      end
    end else if (frame_start) begin
      in_col <= '0;
      in_row <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < 3; r++) begin
        tap_c1[r] <= '0;
        tap_c2[r] <= '0;
      end
    end else if (pix_valid) begin
      for (int r = 0; r < 3; r++) begin
        tap_c1[r] <= tap_c2[r];
        tap_c2[r] <= col_in[r];
      end
    end
  end

  // Window outputs hold their last values between valid pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_valid <= 1'b0;
      win_eof   <= 1'b0;
      win_data  <= '0;
      win_col   <= '0;
      win_row   <= '0;
    end else begin
      win_valid <= win_hit;
      win_eof   <= win_hit && last_pix;
      if (win_hit) begin
        win_data <= next_window;
        win_col  <= eff_col - COL_ONE;
        win_row  <= eff_row - ROW_ONE;
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Bench for window_3x3_gen: an image-array model predicts every output cycle,
// and directed phases pin first/last windows, counts and reset behaviour.
module tb_window_3x3_gen;

  localparam int IMG_W  = 250;
  localparam int IMG_H  = 114;
  localparam int DATA_W = 8;
  localparam int COL_W  = 8;
  localparam int ROW_W  = 7;

  localparam logic [71:0] LIT_A = {8'd246, 8'd245, 8'd244, 8'd252, 8'd251, 8'd250, 8'd2, 8'd1, 8'd0};
  localparam logic [71:0] LIT_B = {8'd9, 8'd10, 8'd11, 8'd3, 8'd4, 8'd5, 8'd253, 8'd254, 8'd255};
  localparam logic [71:0] LIT_D = {8'd90, 8'd89, 8'd88, 8'd96, 8'd95, 8'd94, 8'd102, 8'd101, 8'd100};

  logic                clk = 1'b0;
  logic                rstn;
  logic                frame_start;
  logic                pix_valid;
  logic [DATA_W-1:0]   pix_data;
  logic                win_valid;
  logic [9*DATA_W-1:0] win_data;
  logic [COL_W-1:0]    win_col;
  logic [ROW_W-1:0]    win_row;
  logic                win_eof;

  always #5 clk = ~clk;

  window_3x3_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .COL_W(COL_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .win_valid(win_valid), .win_data(win_data),
    .win_col(win_col), .win_row(win_row), .win_eof(win_eof)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the current frame as a 2-D image, windows cut straight out of it.
  logic [DATA_W-1:0] img [IMG_H][IMG_W];
  int                m_row, m_col;
  int                cur_r, cur_c;
  logic              e_valid, e_eof;
  logic [71:0]       e_data;
  logic [COL_W-1:0]  e_col;
  logic [ROW_W-1:0]  e_row;

  assign cur_r = frame_start ? 0 : m_row;
  assign cur_c = frame_start ? 0 : m_col;

  function automatic logic [71:0] win_at(input int r, input int c, input logic [7:0] px);
    logic [71:0] w;
    w = '0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        w[(3*dr + dc)*8 +: 8] = (dr == 2 && dc == 2) ? px : img[r - 2 + dr][c - 2 + dc];
    return w;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_row <= 0; m_col <= 0;
      e_valid <= 1'b0; e_eof <= 1'b0; e_data <= '0; e_col <= '0; e_row <= '0;
    end else begin
      e_valid <= 1'b0;
      e_eof   <= 1'b0;
      if (pix_valid) begin
        img[cur_r][cur_c] <= pix_data;
        if (cur_r >= 2 && cur_c >= 2) begin
          e_valid <= 1'b1;
          e_data  <= win_at(cur_r, cur_c, pix_data);
          e_col   <= COL_W'(cur_c - 1);
          e_row   <= ROW_W'(cur_r - 1);
          e_eof   <= (cur_r == IMG_H - 1) && (cur_c == IMG_W - 1);
        end
        m_col <= (cur_c == IMG_W - 1) ? 0 : cur_c + 1;
        m_row <= (cur_c != IMG_W - 1) ? cur_r : ((cur_r == IMG_H - 1) ? 0 : cur_r + 1);
      end else if (frame_start) begin
        m_row <= 0; m_col <= 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rstn)
      check("cycle", {39'd0, win_valid, win_eof, win_col, win_row, win_data},
                     {39'd0, e_valid, e_eof, e_col, e_row, e_data});
  end

  // Phase bookkeeping collected by the driver after each clock.
  int               nwin, neof, pix_idx, f_idx;
  logic             seen;
  logic [71:0]      f_data;
  logic [COL_W-1:0] f_col, l_col;
  logic [ROW_W-1:0] f_row, l_row;
  logic             l_eof;

  function automatic logic [7:0] pat(input int sel, input int r, input int c);
    int v;
    v = r * IMG_W + c;
    case (sel)
      1:       return 8'(255 - (v % 256));
      2:       return 8'((v + 100) % 256);
      default: return 8'(v % 256);
    endcase
  endfunction

  task automatic start_phase();
    nwin = 0; neof = 0; pix_idx = 0; seen = 1'b0; f_idx = -1;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic fs);
    @(negedge clk);
    pix_valid = v; pix_data = d; frame_start = fs;
    @(posedge clk);
    #1;
    if (win_valid) begin
      nwin++;
      if (!seen) begin
        seen = 1'b1; f_data = win_data; f_col = win_col; f_row = win_row; f_idx = pix_idx;
      end
      l_col = win_col; l_row = win_row; l_eof = win_eof;
    end
    if (win_eof) neof++;
    if (v) pix_idx++;
  endtask

  task automatic check_first(input string tag, input logic [71:0] exp_data);
    check({tag, "_first_idx"},  128'(f_idx),  128'(502));
    check({tag, "_first_data"}, 128'(f_data), 128'(exp_data));
    check({tag, "_first_col"},  128'(f_col),  128'(1));
    check({tag, "_first_row"},  128'(f_row),  128'(1));
  endtask

  initial begin
    rstn = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    #12;
    check("reset_state", {39'd0, win_valid, win_eof, win_col, win_row, win_data}, 128'd0);
    #10 rstn = 1'b1;

    // Frame A: gap-free ramp.
    start_phase();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        step(1'b1, pat(0, r, c), (r == 0 && c == 0));
    check_first("A", LIT_A);
    check("A_count", 128'(nwin), 128'(27776));
    check("A_eof_count", 128'(neof), 128'(1));
    check("A_last_pos", {l_eof, l_row, l_col}, {1'b1, 7'd112, 8'd248});

    // Frame B: inverted pattern, back-to-back with A.
    start_phase();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        step(1'b1, pat(1, r, c), 1'b0);
    check_first("B", LIT_B);
    check("B_count", 128'(nwin), 128'(27776));
    check("B_eof_count", 128'(neof), 128'(1));

    // Frame C: first four rows with random gaps; windows must equal the gap-free ones.
    start_phase();
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(1, 0) == 0) step(1'b0, 8'($urandom), 1'b0);
      step(1'b1, pat(0, i / IMG_W, i % IMG_W), (i == 0));
    end
    check_first("C", LIT_A);
    check("C_count", 128'(nwin), 128'(496));
    check("C_eof_count", 128'(neof), 128'(0));

    // Frame D: frame_start lands on pixel 1000 of the partial frame C.
    start_phase();
    for (int i = 0; i <= 50 * IMG_W + 100; i++)
      step(1'b1, pat(2, i / IMG_W, i % IMG_W), (i == 0));
    check_first("D", LIT_D);
    check("D_pre_reset", {win_valid, win_row, win_col}, {1'b1, 7'd49, 8'd99});

    // Asynchronous reset mid-row 50, between clock edges.
    #2 rstn = 1'b0;
    pix_valid = 1'b0; frame_start = 1'b0;
    #1;
    check("async_reset", {39'd0, win_valid, win_eof, win_col, win_row, win_data}, 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rstn = 1'b1;

    // After release the next pixel is (0,0) with no frame_start.
    start_phase();
    for (int i = 0; i < 800; i++)
      step(1'b1, pat(1, i / IMG_W, i % IMG_W), 1'b0);
    check_first("E", LIT_B);
    check("E_count", 128'(nwin), 128'(296));

    step(1'b0, 8'd0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Downstream of the pixel ROM read controller. Takes the raster pixel stream read from the image ROM: pix_valid is the ROM read enable delayed by the one-cycle ROM read latency.
- Uses two on-chip line buffers to build a sliding 3x3 neighbourhood.
- Emits one window per interior pixel for the filter stage (Sobel/median) that follows.
- Frame geometry: IMG_W x IMG_H raster, row-major, no blanking information needed.

Parameters:
- IMG_W, 250, pixels per line
- IMG_H, 114, lines per frame
- DATA_W, 8, bits per pixel
- COL_W, 8, width of column counters (must hold IMG_W-1)
- ROW_W, 7, width of row counters (must hold IMG_H-1)

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- frame_start  input  1  single-cycle pulse; re-aligns input counters to pixel (0,0)
- pix_valid  input  1  pix_data carries a pixel this cycle
- pix_data  input  DATA_W  pixel value
- win_valid  output  1  win_data/win_col/win_row valid this cycle
- win_data  output  9*DATA_W  3x3 window; tap k=3*r+c (r=0 top row, c=0 left column) at bits [k*DATA_W +: DATA_W]; k=4 is centre
- win_col  output  COL_W  column of centre pixel
- win_row  output  ROW_W  row of centre pixel
- win_eof  output  1  high with the last window of a frame

Behaviour:
- Reset (rstn low, async): in_col=0, in_row=0, win_valid=0, win_eof=0, win_data=0, win_col=0, win_row=0, column shift registers cleared. Line buffer RAM contents are not cleared.
- Input counters advance only on pix_valid. in_col wraps IMG_W-1 -> 0 and increments in_row; in_row wraps IMG_H-1 -> 0. Frames repeat back-to-back.
- Gaps: pix_valid may drop for any number of cycles at any position. All state holds and the output stream content is identical to the gap-free case.
- Line buffers: lb0 and lb1, depth IMG_W, addressed by in_col. On pix_valid, read lb0[in_col] (one row up) and lb1[in_col] (two rows up), then write lb1[in_col]<=old lb0[in_col] and lb0[in_col]<=pix_data. Read-before-write in the same cycle.
- Window shift on pix_valid: each row shifts left (c0<=c1, c1<=c2). New c2 values are: top = lb1 read, middle = lb0 read, bottom = pix_data.
- Valid rule: win_valid=1 in the cycle after a pix_valid cycle with in_row>=2 and in_col>=2; otherwise 0. Outputs are registered; latency is 1 cycle from accepting the bottom-right pixel.
- Centre position: win_col=in_col-1 and win_row=in_row-1, sampled from the accepting cycle.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) never appear as centre. Windows per frame = (IMG_W-2)*(IMG_H-2) = 27776 at defaults.
- Row wrap: stale taps from the previous line's end are never emitted, because of the in_col>=2 gating.
- win_eof=1 together with win_valid for the window whose input was (IMG_H-1, IMG_W-1); otherwise 0.
- When win_valid=0, win_data/win_col/win_row hold their last values.
- frame_start: synchronous. Forces in_col=0, in_row=0 before evaluating the same cycle's pixel, so a pixel accepted with frame_start is (0,0). No window is emitted for that cycle. Taps from a partially received frame are flushed by the row/col gating.
- Reset mid-frame: outputs drop to 0 asynchronously. After release, the next accepted pixel is treated as (0,0).

Test Plan:
- Gap-free frame, pix_data=(row*250+col) mod 256 -> first win_valid one cycle after pixel index 502 accepted. win_data taps k0..k8 = 0,1,2,250,251,252,500,501,502 mod 256 (i.e. 0,1,2,250,251,252,244,245,246); win_col=1, win_row=1.
- Same frame, count outputs -> exactly 27776 win_valid pulses. Last window has win_col=248, win_row=112, win_eof=1. Exactly one win_eof per frame.
- Random 50% pix_valid duty -> window sequence (data, col, row) identical to the gap-free run. No win_valid in cycles following a pix_valid=0 cycle.
- Two consecutive frames with different patterns (second = 255-first) -> second frame's first window taps are all from the second frame; count is 27776 again.
- frame_start pulse at input pixel index 1000, then full frame -> no win_valid until 502 pixels after the pulse. First centre (1,1) matches new data.
- rstn asserted mid-row 50 -> win_valid=0 immediately, without waiting for a clock edge. After release plus a full frame, outputs match the reference model exactly.
